// File: rtl/gen_pkg.sv
// gen_pkg: shared state encoding and timing helpers for the half-bridge generator
`include "gen_defines.svh"
package gen_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE, HALF_A, HALF_B} state_t;
  function automatic int cnt_min(input int clk_mhz, input int freq_khz_max);
    return `DIV(500 * clk_mhz, freq_khz_max);
  endfunction
endpackage

// File: rtl/gen_defines.svh
`ifndef GEN_DEFINES_SVH
`define GEN_DEFINES_SVH
`define DIV(a, b) ((a) / (b))
`define WIDTH(x) ($clog2((x) + 1))
`define WIRE(x) [`WIDTH(x)-1:0]
`define REG(x) logic `WIRE(x)
`endif

// File: rtl/gen_hbridge.sv
// gen_hbridge: complementary half-bridge gate pattern with dead time, glitch-free period reload, run gating and sticky fault
//   clk, rst_n (sync, active-low) | run: oscillation request | fault: abort, highest priority
//   ld/inp: shadow load of period parameter p, half-period H = CNT_MIN + p
//   out_a/out_b: phase drives | sync: first clock of each A half | busy: not idle | flt: sticky fault
`include "gen_defines.svh"
module gen_hbridge
  import gen_pkg::*;
#(
  parameter int CLK_MHZ      = 100,
  parameter int FREQ_KHZ_MIN = 100,
  parameter int FREQ_KHZ_MAX = 400,
  parameter int PARAM_MAX    = 255,
  parameter int DEAD_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  fault,
  input  logic                  ld,
  input  logic `WIRE(PARAM_MAX) inp,
  output logic                  out_a,
  output logic                  out_b,
  output logic                  sync,
  output logic                  busy,
  output logic                  flt
);
  localparam int CNT_MIN = cnt_min(CLK_MHZ, FREQ_KHZ_MAX);
  localparam int CW = `WIDTH(CNT_MIN + PARAM_MAX);
  if (DEAD_CYCLES >= CNT_MIN) begin : g_bad_dead
    $error("gen_hbridge: DEAD_CYCLES must be below CNT_MIN");
  end
  if (FREQ_KHZ_MIN > FREQ_KHZ_MAX) begin : g_bad_freq
    $error("gen_hbridge: FREQ_KHZ_MIN exceeds FREQ_KHZ_MAX");
  end
  state_t state, st_n;
  logic [CW-1:0] cnt, cnt_n, h;
  `REG(PARAM_MAX) shadow, active, act_n;
  logic flt_n, bnd;
  assign busy = state != IDLE;
  // The half length always comes from active, which only moves at a start or a
  // half boundary, so a mid-half ld can never stretch or cut the running half.
  always_comb begin
    h = CW'(CNT_MIN) + CW'(active);
    bnd = state != IDLE && cnt == h - 1'b1;
    st_n = state;
    cnt_n = cnt + 1'b1;
    act_n = active;
    flt_n = flt;
    if (fault) begin
      st_n = IDLE;
      cnt_n = '0;
      flt_n = 1'b1;
    end else if (state == IDLE) begin
      cnt_n = '0;
      flt_n = flt && run;
      if (run && !flt) begin
        st_n = HALF_A;
        act_n = shadow;
      end
    end else if (bnd) begin
      cnt_n = '0;
      act_n = ld ? inp : shadow;
      st_n = state == HALF_A ? HALF_B : run ? HALF_A : IDLE;
    end
  end
  // Outputs decode the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      shadow <= '0;
      active <= '0;
      flt <= 1'b0;
      out_a <= 1'b0;
      out_b <= 1'b0;
      sync <= 1'b0;
    end else begin
      state <= st_n;
      cnt <= cnt_n;
      shadow <= ld ? inp : shadow;
      active <= act_n;
      flt <= flt_n;
      out_a <= st_n == HALF_A && cnt_n >= CW'(DEAD_CYCLES);
      out_b <= st_n == HALF_B && cnt_n >= CW'(DEAD_CYCLES);
      sync <= st_n == HALF_A && cnt_n == '0;
    end
  end
endmodule
